// File: rtl/mips_trace_buffer.sv
`default_nettype none
// ============================================================================
// mips_trace_buffer: triggered capture of retired instructions (PC, word,
// timestamp) into a circular buffer with a FIFO-style pop port.
// Revision: 1.0
// ============================================================================
module mips_trace_buffer #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   trig_en,
    input  logic [PC_W-1:0]        trig_pc,
    input  logic                   wrap_mode,
    input  logic                   in_valid,
    input  logic [PC_W-1:0]        in_pc,
    input  logic [INST_W-1:0]      in_instr,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic [PC_W-1:0]        rd_pc,
    output logic [INST_W-1:0]      rd_instr,
    output logic [TS_W-1:0]        rd_ts,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             state,
    output logic                   overflow
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam int c_ew = PC_W + INST_W + TS_W;
    localparam logic [c_cw-1:0] c_full    = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
    localparam logic [TS_W-1:0] c_ts_one  = TS_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_ew-1:0] r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic [c_cw-1:0] w_count_nxt;
    logic [TS_W-1:0] r_ts;
    logic            r_overflow;
    logic            w_full;
    logic            w_accept;
    logic            w_pop;
    logic            w_write;
    logic            w_overwrite;

    // arm overrides everything in its cycle: samples and pops are both dropped.
    always_comb begin
        w_full      = (r_count == c_full);
        w_pop       = rd_en && !arm && (r_count != '0);
        w_accept    = in_valid && !arm &&
                      ((r_state == S_CAPTURE) ||
                       ((r_state == S_ARMED) && (in_pc == trig_pc)));
        w_write     = w_accept && (!w_full || wrap_mode || w_pop);
        w_overwrite = w_write && w_full && !w_pop;
        w_count_nxt = r_count;
        w_state_nxt = r_state;
        if (arm) begin
            w_count_nxt = '0;
            w_state_nxt = trig_en ? S_ARMED : S_CAPTURE;
        end else begin
            if (w_write && !w_pop && !w_full) begin
                w_count_nxt = r_count + c_cnt_one;
            end else if (w_pop && !w_write) begin
                w_count_nxt = r_count - c_cnt_one;
            end
            case (r_state)
                S_ARMED: begin
                    if (w_write) w_state_nxt = S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (w_write && !wrap_mode && (w_count_nxt == c_full)) begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts       <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            rd_valid   <= 1'b0;
            rd_pc      <= '0;
            rd_instr   <= '0;
            rd_ts      <= '0;
        end else begin
            r_ts     <= r_ts + c_ts_one;
            r_count  <= w_count_nxt;
            rd_valid <= w_pop;
            if (arm) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_write) r_wr_ptr <= r_wr_ptr + c_ptr_one;
                // An overwrite at full discards the oldest entry, so the read side moves too.
                if (w_pop || w_overwrite) r_rd_ptr <= r_rd_ptr + c_ptr_one;
                if (w_overwrite) r_overflow <= 1'b1;
            end
            if (w_pop) begin
                {rd_pc, rd_instr, rd_ts} <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {in_pc, in_instr, r_ts};
        end
    end

    assign count    = r_count;
    assign state    = r_state;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mips_trace_buffer.sv
`default_nettype none
// Testbench for mips_trace_buffer: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_mips_trace_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        wrap_mode = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        rd_en = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [15:0] rd_ts;
    logic [4:0]  count;
    logic [1:0]  state;
    logic        overflow;

    mips_trace_buffer #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH), .TS_W(16)) dut (
        .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .wrap_mode(wrap_mode), .in_valid(in_valid), .in_pc(in_pc),
        .in_instr(in_instr), .rd_en(rd_en), .rd_valid(rd_valid), .rd_pc(rd_pc),
        .rd_instr(rd_instr), .rd_ts(rd_ts), .count(count), .state(state),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] ts;
    } ent_t;

    int          total = 0;
    int          bad = 0;
    ent_t        q[$];
    int          m_state = 0;
    bit          m_ovf = 0;
    bit          m_rv = 0;
    ent_t        m_rd;
    logic [15:0] m_ts = '0;
    logic [15:0] last_ts;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the buffer is a bounded queue; each edge applies arm, pop, then store.
    task automatic model_edge();
        ent_t e;
        bit   pop;
        bit   wrote;
        e.pc    = in_pc;
        e.instr = in_instr;
        e.ts    = m_ts;
        m_ts    = m_ts + 16'd1;
        pop     = rd_en && !arm && (q.size() > 0);
        m_rv    = pop;
        wrote   = 0;
        if (arm) begin
            q.delete();
            m_ovf   = 0;
            m_state = trig_en ? 1 : 2;
        end else begin
            if (pop) m_rd = q.pop_front();
            if (in_valid && (m_state == 2 || (m_state == 1 && in_pc == trig_pc))) begin
                if (q.size() < DEPTH) begin
                    q.push_back(e);
                    wrote = 1;
                    if (m_state == 1) m_state = 2;
                end else if (wrap_mode) begin
                    void'(q.pop_front());
                    q.push_back(e);
                    m_ovf = 1;
                    wrote = 1;
                end
                if (wrote && m_state == 2 && !wrap_mode && q.size() == DEPTH) m_state = 3;
            end
        end
    endtask

    task automatic check_all();
        chk("state", 64'(state), 64'(m_state));
        chk("count", 64'(count), 64'(q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("rd_valid", 64'(rd_valid), 64'(m_rv));
        if (m_rv) begin
            chk("rd_pc", 64'(rd_pc), 64'(m_rd.pc));
            chk("rd_instr", 64'(rd_instr), 64'(m_rd.instr));
            chk("rd_ts", 64'(rd_ts), 64'(m_rd.ts));
        end
    endtask

    task automatic step(input bit a, input bit v, input logic [31:0] p, input bit r);
        arm      = a;
        in_valid = v;
        in_pc    = p;
        in_instr = $urandom;
        rd_en    = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 64'(state), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_rv"}, 64'(rd_valid), 64'd0);
        chk({tag, "_rdpc"}, 64'(rd_pc), 64'd0);
        chk({tag, "_rdinstr"}, 64'(rd_instr), 64'd0);
        chk({tag, "_rdts"}, 64'(rd_ts), 64'd0);
    endtask

    initial begin
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Immediate capture of three samples, then ordered pops.
        trig_en = 1'b0;
        wrap_mode = 1'b0;
        step(1, 1, 32'h40, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 32'(k * 4), 0);
        step(0, 0, 0, 1);
        last_ts = rd_ts;
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 0, 1);
            chk("ts_incr", 64'(rd_ts > last_ts), 64'd1);
            last_ts = rd_ts;
        end
        step(0, 0, 0, 1);

        // Triggered capture starting at 0x10.
        trig_en = 1'b1;
        trig_pc = 32'h10;
        step(1, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 1, 32'(k * 4), 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1);

        // Stop-when-full with 20 samples, then drain.
        trig_en = 1'b0;
        step(1, 0, 0, 0);
        for (int k = 1; k <= 20; k++) step(0, 1, 32'(k * 4), 0);
        for (int k = 0; k < 17; k++) step(0, 0, 0, 1);

        // Wrap mode with 20 samples, then drain.
        wrap_mode = 1'b1;
        step(1, 0, 0, 0);
        for (int k = 1; k <= 20; k++) step(0, 1, 32'(k * 4), 0);
        for (int k = 0; k < 17; k++) step(0, 0, 0, 1);

        // Full in wrap mode: simultaneous write and pop.
        step(1, 0, 0, 0);
        for (int k = 1; k <= 16; k++) step(0, 1, 32'(k * 4), 0);
        step(0, 1, 32'h100, 1);
        step(0, 1, 32'h104, 1);

        // Random traffic, sessions restarted periodically.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                trig_en = 1'($urandom_range(0, 1));
                trig_pc = 32'($urandom_range(0, 7)) * 4;
            end
            if ($urandom_range(0, 19) == 0) wrap_mode = ~wrap_mode;
            step((i % 50 == 0) || ($urandom_range(0, 39) == 0),
                 $urandom_range(0, 2) != 0,
                 32'($urandom_range(0, 7)) * 4,
                 $urandom_range(0, 2) == 0);
        end

        // Asynchronous reset mid-capture at count 7.
        wrap_mode = 1'b0;
        trig_en = 1'b0;
        step(1, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 1, 32'(k * 4 + 32'h200), 0);
        step(0, 0, 0, 1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        q.delete();
        m_state = 0;
        m_ovf   = 0;
        m_rv    = 0;
        arm = 1'b0;
        in_valid = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_ts = '0;
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 32'(k * 4), 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_trace_buffer.md
MIPS_TRACE_BUFFER -- requirements
Module: mips_trace_buffer

Interface
REQ-001 Parameter PC_W, default 32, width of the captured program counter.
REQ-002 Parameter INST_W, default 32, width of the captured instruction word.
REQ-003 Parameter DEPTH, default 16, number of trace entries; SHALL be a power of two and at least 2.
REQ-004 Parameter TS_W, default 16, width of the cycle timestamp.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 arm  input  1  one-cycle pulse; clears the buffer and starts a capture session.
REQ-008 trig_en  input  1  1 = wait for a PC match before capturing; 0 = capture immediately.
REQ-009 trig_pc  input  PC_W  trigger address.
REQ-010 wrap_mode  input  1  0 = stop when full; 1 = overwrite oldest entry.
REQ-011 in_valid  input  1  retired instruction present this cycle.
REQ-012 in_pc  input  PC_W  PC of the retired instruction.
REQ-013 in_instr  input  INST_W  retired instruction word.
REQ-014 rd_en  input  1  pop request for the oldest entry.
REQ-015 rd_valid  output  1  rd_pc, rd_instr and rd_ts are valid this cycle.
REQ-016 rd_pc  output  PC_W  popped PC.
REQ-017 rd_instr  output  INST_W  popped instruction.
REQ-018 rd_ts  output  TS_W  popped timestamp.
REQ-019 count  output  clog2(DEPTH)+1  number of stored entries.
REQ-020 state  output  2  FSM state encoding: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-021 overflow  output  1  sticky flag; at least one entry was overwritten in the current session.

Function
REQ-022 The free-running timestamp counter SHALL increment every cycle and wrap from 2^TS_W-1 to 0; it is not cleared by arm.
REQ-023 In IDLE, arm SHALL go to ARMED if trig_en=1, otherwise to CAPTURE.
REQ-024 arm in any state SHALL clear pointers, count and overflow, then take the IDLE transition of REQ-023; any in_valid in the arm cycle SHALL be ignored.
REQ-025 In ARMED, in_valid with in_pc==trig_pc SHALL store that sample and go to CAPTURE; non-matching samples SHALL be discarded.
REQ-026 In CAPTURE, each in_valid SHALL store {in_pc, in_instr, current timestamp} at the write pointer, and count SHALL increment.
REQ-027 With wrap_mode=0, the write that makes count equal DEPTH SHALL cause a transition to DONE in the same edge; later in_valid SHALL be discarded.
REQ-028 With wrap_mode=1 and count==DEPTH, a write without a pop SHALL overwrite the oldest entry, advance the read pointer, hold count at DEPTH and set overflow.
REQ-029 Pointers SHALL wrap modulo DEPTH.
REQ-030 rd_en with count>0 SHALL pop the oldest entry; rd_valid SHALL be 1 on the following cycle with the registered data; otherwise rd_valid=0.
REQ-031 rd_en with count==0 SHALL be ignored: no pointer change and rd_valid=0 on the next cycle.
REQ-032 A write and a pop in the same cycle SHALL leave count unchanged; at count==DEPTH in wrap mode this SHALL NOT set overflow.
REQ-033 A write and a pop in the same cycle at count==0 SHALL store the entry and pop nothing (count becomes 1).
REQ-034 Reads SHALL be permitted in every state, including DONE and IDLE.
REQ-035 wrap_mode and trig_pc SHALL be sampled every cycle; changing them mid-session takes effect on the next edge.

Reset
REQ-036 While rst=1: state=IDLE, count=0, pointers=0, timestamp=0, overflow=0, rd_valid=0, rd_pc=0, rd_instr=0 and rd_ts=0, regardless of clk.
REQ-037 Reset asserted mid-capture SHALL discard all stored entries; no entry survives reset.

Verification
REQ-038 arm with trig_en=0, then 3 in_valid samples with PC 0x00,0x04,0x08 -> count=3; three pops return the PCs in order with strictly increasing rd_ts.
REQ-039 trig_en=1, trig_pc=0x10, feed PCs 0x00..0x1C at step 4 -> the first entry is 0x10; count=4; state=CAPTURE.
REQ-040 DEPTH=16, wrap_mode=0, feed 20 samples -> state=DONE after the 16th; count=16; entries are samples 1..16; overflow=0.
REQ-041 wrap_mode=1, feed 20 samples -> count=16; overflow=1; the first pop returns sample 5.
REQ-042 At count=16 in wrap mode, simultaneous in_valid and rd_en -> count=16; overflow stays 0; the popped entry is the oldest.
REQ-043 rst asserted asynchronously between edges during CAPTURE with count=7 -> outputs reach their reset values immediately; a pop after release gives rd_valid=0.
